// File: rtl/bus_ram_responder_pkg.sv
// Shared bus widths, FSM state encoding and wait-counter width for the RAM responder.
package bus_ram_responder_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/bus_ram_bytemem.sv
// Single-port synchronous RAM with per-byte write enables; no reset so it maps onto block RAM.
module bus_ram_bytemem
  import bus_ram_responder_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int IW    = 11
) (
  input  logic              clock_i,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [IW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [STRB_W-1:0][7:0] mem [DEPTH];

  // Read-first: a read port access returns the word as it was before this edge's write.
  always_ff @(posedge clock_i) begin
    if (en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (we[i]) mem[addr][i] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_ram_responder.sv
// Bus RAM device: accepts one request at a time, inserts WAIT_CYCLES wait states, pulses a response.
module bus_ram_responder
  import bus_ram_responder_pkg::*;
#(
  parameter int MEM_SIZE_BYTES = 8192,
  parameter int WAIT_CYCLES    = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [31:0]       rw_address_i,
  output logic [DATA_W-1:0] read_data_o,
  input  logic              read_request_i,
  output logic              read_response_o,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [STRB_W-1:0] write_strobe_i,
  input  logic              write_request_i,
  output logic              write_response_o,
  output state_t            debug_state
);

  // Handshake: a request is held high by the host until its response pulse; the device
  // accepts only in IDLE and raises exactly one response for one cycle per acceptance.

  localparam int AW    = $clog2(MEM_SIZE_BYTES);
  localparam int IW    = AW - 2;
  localparam int DEPTH = MEM_SIZE_BYTES / 4;
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              op_write_q;
  logic              read_resp_q;
  logic              write_resp_q;

  logic              req_any;
  logic              accept;
  logic              commit;
  logic [IW-1:0]     mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_strb;
  logic              mem_write;
  logic [STRB_W-1:0] mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic unused_addr;
  assign unused_addr = ^{rw_address_i[1:0], rw_address_i[31:AW]};

  assign req_any = read_request_i | write_request_i;
  assign accept  = (state == ST_IDLE) && req_any;

  // The RAM is touched only at the edge entering RESP; with no wait states that edge is
  // the acceptance edge itself, so the live request inputs feed the RAM directly.
  always_comb begin
    commit    = 1'b0;
    mem_idx   = idx_q;
    mem_wdata = wdata_q;
    mem_strb  = strb_q;
    mem_write = op_write_q;
    if (accept) begin
      mem_idx   = rw_address_i[AW-1:2];
      mem_wdata = write_data_i;
      mem_strb  = write_strobe_i;
      mem_write = write_request_i;
    end
    if (WAIT_CYCLES == 0) commit = accept;
    else                  commit = (state == ST_WAIT) && (wait_cnt == WAIT_CNT);
    if (reset_i) commit = 1'b0;
    mem_we = (commit && mem_write) ? mem_strb : '0;
  end

  bus_ram_bytemem #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clock_i (clock_i),
    .en      (commit),
    .we      (mem_we),
    .addr    (mem_idx),
    .wdata   (mem_wdata),
    .rdata   (mem_rdata)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      op_write_q   <= 1'b0;
      read_resp_q  <= 1'b0;
      write_resp_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            idx_q      <= rw_address_i[AW-1:2];
            wdata_q    <= write_data_i;
            strb_q     <= write_strobe_i;
            // A simultaneous read stays pending; the host keeps it asserted.
            op_write_q <= write_request_i;
            if (WAIT_CYCLES == 0) begin
              state        <= ST_RESP;
              write_resp_q <= write_request_i;
              read_resp_q  <= ~write_request_i;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= CNT_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_CNT) begin
            state        <= ST_RESP;
            wait_cnt     <= '0;
            write_resp_q <= op_write_q;
            read_resp_q  <= ~op_write_q;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state        <= ST_IDLE;
          read_resp_q  <= 1'b0;
          write_resp_q <= 1'b0;
        end
        default: begin
          state        <= ST_IDLE;
          read_resp_q  <= 1'b0;
          write_resp_q <= 1'b0;
        end
      endcase
    end
  end

  assign read_response_o  = read_resp_q;
  assign write_response_o = write_resp_q;
  assign read_data_o      = read_resp_q ? mem_rdata : '0;
  assign debug_state      = state;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed bench: three responder instances with 0, 3 and 2 wait states driven by one sequence.
module tb_bus_ram_responder;
  import bus_ram_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst      [3];
  logic [31:0] addr     [3];
  logic [31:0] rd_data  [3];
  logic        rd_req   [3];
  logic        rd_rsp   [3];
  logic [31:0] wdata    [3];
  logic [3:0]  strb     [3];
  logic        wr_req   [3];
  logic        wr_rsp   [3];
  state_t      st       [3];

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] got;

  always #5 clk = ~clk;

  // Instance index 0: WAIT_CYCLES=0, 1: WAIT_CYCLES=3, 2: WAIT_CYCLES=2.
  bus_ram_responder #(.MEM_SIZE_BYTES(8192), .WAIT_CYCLES(0)) dut0 (
    .clock_i(clk), .reset_i(rst[0]), .rw_address_i(addr[0]), .read_data_o(rd_data[0]),
    .read_request_i(rd_req[0]), .read_response_o(rd_rsp[0]), .write_data_i(wdata[0]),
    .write_strobe_i(strb[0]), .write_request_i(wr_req[0]), .write_response_o(wr_rsp[0]),
    .debug_state(st[0]));

  bus_ram_responder #(.MEM_SIZE_BYTES(8192), .WAIT_CYCLES(3)) dut3 (
    .clock_i(clk), .reset_i(rst[1]), .rw_address_i(addr[1]), .read_data_o(rd_data[1]),
    .read_request_i(rd_req[1]), .read_response_o(rd_rsp[1]), .write_data_i(wdata[1]),
    .write_strobe_i(strb[1]), .write_request_i(wr_req[1]), .write_response_o(wr_rsp[1]),
    .debug_state(st[1]));

  bus_ram_responder #(.MEM_SIZE_BYTES(8192), .WAIT_CYCLES(2)) dut2 (
    .clock_i(clk), .reset_i(rst[2]), .rw_address_i(addr[2]), .read_data_o(rd_data[2]),
    .read_request_i(rd_req[2]), .read_response_o(rd_rsp[2]), .write_data_i(wdata[2]),
    .write_strobe_i(strb[2]), .write_request_i(wr_req[2]), .write_response_o(wr_rsp[2]),
    .debug_state(st[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue a write at a negedge and wait (bounded) for its response pulse.
  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] data,
                          input logic [3:0] s, input int exp_lat);
    int lat = 0;
    bit seen = 0;
    addr[d] = a; wdata[d] = data; strb[d] = s; wr_req[d] = 1'b1;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      check("wr_no_rd_rsp", 32'(rd_rsp[d]), 32'd0);
      if (wr_rsp[d]) seen = 1;
    end
    wr_req[d] = 1'b0;
    check("wr_seen", 32'(seen), 32'd1);
    check("wr_latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check("wr_rsp_pulse_end", 32'(wr_rsp[d]), 32'd0);
  endtask

  // Issue a read; read_data must stay 0 outside the response cycle.
  task automatic do_read(input int d, input logic [31:0] a, input int exp_lat,
                         output logic [31:0] data);
    int lat = 0;
    bit seen = 0;
    data = 32'hxxxx_xxxx;
    addr[d] = a; rd_req[d] = 1'b1;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      check("rd_no_wr_rsp", 32'(wr_rsp[d]), 32'd0);
      if (rd_rsp[d]) begin
        seen = 1;
        data = rd_data[d];
      end else begin
        check("rd_data_zero_wait", rd_data[d], 32'd0);
      end
    end
    rd_req[d] = 1'b0;
    check("rd_seen", 32'(seen), 32'd1);
    check("rd_latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check("rd_rsp_pulse_end", 32'(rd_rsp[d]), 32'd0);
    check("rd_data_zero_after", rd_data[d], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; addr[d] = '0; rd_req[d] = 1'b0; wdata[d] = '0;
      strb[d] = '0; wr_req[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_state", 32'(st[d]), 32'(ST_IDLE));
      check("reset_rd_rsp", 32'(rd_rsp[d]), 32'd0);
      check("reset_wr_rsp", 32'(wr_rsp[d]), 32'd0);
      check("reset_rd_data", rd_data[d], 32'd0);
    end
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);

    // No wait states: one-cycle write and read latency.
    do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 1);
    do_read(0, 32'h10, 1, got);
    check("t1_read", got, 32'hDEADBEEF);

    // Byte strobes, including the all-zero strobe no-op.
    do_write(0, 32'h0, 32'h11223344, 4'hF, 1);
    do_write(0, 32'h0, 32'hAABBCCDD, 4'b0101, 1);
    do_read(0, 32'h0, 1, got);
    check("t2_strobe", got, 32'h11BB33DD);
    do_write(0, 32'h10, 32'h00000000, 4'b0000, 1);
    do_read(0, 32'h10, 1, got);
    check("t2_zero_strobe", got, 32'hDEADBEEF);

    // Address wrap and ignored byte offset.
    do_write(0, 32'h2004, 32'hCAFEF00D, 4'hF, 1);
    do_read(0, 32'h0004, 1, got);
    check("t4_wrap", got, 32'hCAFEF00D);
    do_read(0, 32'h0007, 1, got);
    check("t4_offset", got, 32'hCAFEF00D);

    // Read and write together: write first, read pending, then post-write data.
    do_write(0, 32'h8, 32'hFFFFFFFF, 4'hF, 1);
    addr[0] = 32'h8; wdata[0] = 32'h5; strb[0] = 4'hF;
    rd_req[0] = 1'b1; wr_req[0] = 1'b1;
    @(negedge clk);
    check("t5_wr_first", 32'(wr_rsp[0]), 32'd1);
    check("t5_no_rd_yet", 32'(rd_rsp[0]), 32'd0);
    wr_req[0] = 1'b0;
    @(negedge clk);
    check("t5_gap_wr", 32'(wr_rsp[0]), 32'd0);
    check("t5_gap_rd", 32'(rd_rsp[0]), 32'd0);
    @(negedge clk);
    check("t5_rd_rsp", 32'(rd_rsp[0]), 32'd1);
    check("t5_rd_only", 32'(wr_rsp[0]), 32'd0);
    check("t5_rd_data", rd_data[0], 32'h5);
    rd_req[0] = 1'b0;
    @(negedge clk);
    check("t5_done", 32'(rd_rsp[0]), 32'd0);

    // Three wait states: response four cycles after acceptance.
    do_write(1, 32'h20, 32'h0BADC0DE, 4'hF, 4);
    do_read(1, 32'h20, 4, got);
    check("t3_read", got, 32'h0BADC0DE);

    // Two wait states: reset during WAIT aborts the write.
    do_write(2, 32'hC, 32'h55AA55AA, 4'hF, 3);
    addr[2] = 32'hC; wdata[2] = 32'h1234; strb[2] = 4'hF; wr_req[2] = 1'b1;
    @(negedge clk);
    check("t6_in_wait", 32'(st[2]), 32'(ST_WAIT));
    check("t6_no_rsp", 32'(wr_rsp[2]), 32'd0);
    rst[2] = 1'b1;
    @(negedge clk);
    check("t6_reset_idle", 32'(st[2]), 32'(ST_IDLE));
    rst[2] = 1'b0; wr_req[2] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t6_no_late_rsp", 32'(wr_rsp[2]), 32'd0);
    end
    do_read(2, 32'hC, 3, got);
    check("t6_unchanged", got, 32'h55AA55AA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
